apb_arbiter_rr: RTL and testbench
=================================

APB_ARBITER_RR -- requirements
Module: apb_arbiter_rr

Interface
REQ-001 SHALL provide parameters: NUM_CH, default 4, number of APB requester channels (2..8); ADDR_WIDTH, default 21, address bits; DATA_WIDTH, default 16, data bits; TO_WIDTH, default 16, timeout counter bits.
REQ-002 SHALL provide ports, clock and reset first:
  clk  in  1  clock
  rstn  in  1  reset, asynchronous, active-low
  cfg_timeout  in  TO_WIDTH  timeout limit in clk cycles; 0 disables timeout
  cfg_fixed_prio  in  1  arbitration mode: 0 round-robin, 1 fixed priority (ch0 highest)
  s_psel  in  NUM_CH  per-channel psel
  s_penable  in  NUM_CH  per-channel penable
  s_pwrite  in  NUM_CH  per-channel pwrite
  s_paddr  in  NUM_CH*ADDR_WIDTH  packed addresses; ch i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
  s_pwdata  in  NUM_CH*DATA_WIDTH  packed write data, same packing
  s_prdata  out  DATA_WIDTH  read data, shared by all channels
  s_pready  out  NUM_CH  per-channel pready
  s_pslverr  out  NUM_CH  per-channel pslverr
  req_sel  out  1  downstream request valid
  req_write  out  1  downstream write
  req_addr  out  ADDR_WIDTH  downstream address
  req_wdata  out  DATA_WIDTH  downstream write data
  req_ready  in  1  downstream completion
  req_rdata  in  DATA_WIDTH  downstream read data, valid with req_ready
  req_err  in  1  downstream error, valid with req_ready
  busy  out  1  FSM not in IDLE
  grant_id  out  $clog2(NUM_CH)  currently or last granted channel
  timeout_evt  out  1  one-cycle pulse on entry to ERR

Function
REQ-003 Channel i SHALL be requesting when s_psel[i] & s_penable[i] = 1.
REQ-004 FSM SHALL have states IDLE, REQ, RESP, ERR; all outputs SHALL be registered.
REQ-005 IDLE: any channel requesting -> select winner; latch its pwrite, paddr, pwdata into req_*; set grant_id; assert req_sel; go to REQ.
REQ-006 Round-robin mode: winner = first requesting channel at or after rr_ptr, searching upward with wrap; rr_ptr SHALL become (winner+1) mod NUM_CH when the transfer completes in RESP or ERR.
REQ-007 Fixed mode: winner = lowest-index requesting channel; rr_ptr unchanged.
REQ-008 REQ: req_sel = 1, req_* stable; to_cnt starts at 1 on the first REQ cycle and increments by 1 per cycle; saturates, no wrap.
REQ-009 REQ with req_ready = 1: capture req_rdata into s_prdata and req_err into the granted channel's s_pslverr; deassert req_sel; go to RESP. req_ready takes priority over timeout in the same cycle.
REQ-010 REQ, req_ready = 0, cfg_timeout != 0, to_cnt == cfg_timeout: deassert req_sel; pulse timeout_evt; go to ERR.
REQ-011 RESP: s_pready[grant_id] = 1 for exactly one cycle; then go to IDLE.
REQ-012 ERR: s_pready[grant_id] = 1 and s_pslverr[grant_id] = 1 for exactly one cycle; s_prdata = 0; then go to IDLE.
REQ-013 At most one s_pready bit SHALL be high in any cycle; non-granted channels SHALL see pready = 0 and pslverr = 0.
REQ-014 req_ready outside REQ SHALL be ignored.
REQ-015 A new grant SHALL NOT be issued in the cycle after RESP/ERR unless a channel is requesting in IDLE; minimum spacing between req_sel assertions is 3 cycles.
REQ-016 Latency: requester valid at edge N -> req_sel high after edge N+1; req_ready at edge M -> s_pready high after edge M+1.
REQ-017 A channel dropping psel during REQ SHALL NOT abort the transfer; the response is still delivered.
REQ-018 cfg_timeout and cfg_fixed_prio changes SHALL take effect at the next IDLE->REQ decision; to_cnt compares against the live cfg_timeout.

Reset
REQ-019 On rstn low, asynchronously: state = IDLE, rr_ptr = 0, to_cnt = 0, grant_id = 0, and all outputs 0.
REQ-020 Reset during REQ SHALL abandon the transfer; no pready is issued after reset release.

Verification
REQ-021 Ch1 read alone, addr 0x00123, req_ready after 3 cycles with rdata 0xBEEF -> s_pready[1] high for one cycle, s_prdata = 0xBEEF, s_pslverr[1] = 0.
REQ-022 Round-robin, ch0..ch3 all requesting continuously, NUM_CH = 4 -> grant order 0,1,2,3,0.
REQ-023 Fixed priority, ch0 and ch2 requesting -> ch0 granted first, ch2 granted next.
REQ-024 cfg_timeout = 5, req_ready never asserted -> req_sel high for 5 cycles, timeout_evt pulses once, then s_pready and s_pslverr of the granted channel high for one cycle.
REQ-025 cfg_timeout = 5, req_ready on cycle 5 -> normal RESP, no error; cfg_timeout = 0 with 1000-cycle stall -> no timeout.
REQ-026 rstn asserted mid-REQ -> all outputs 0 immediately; after release, first grant follows REQ-006 from rr_ptr = 0.

Source files
------------

// File: rtl/apb_arbiter_rr.sv
// apb_arbiter_rr: arbitrates NUM_CH APB requesters onto one downstream request port.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   cfg_timeout               REQ-phase timeout in cycles (0 disables)
//   cfg_fixed_prio            0 round-robin, 1 fixed priority (ch0 highest)
//   s_psel/s_penable/s_pwrite per-channel APB control
//   s_paddr/s_pwdata          packed per-channel address / write data
//   s_prdata                  shared read data
//   s_pready/s_pslverr        per-channel completion / error
//   req_sel/req_write/req_addr/req_wdata  downstream request
//   req_ready/req_rdata/req_err           downstream completion
//   busy, grant_id, timeout_evt           status
module apb_arbiter_rr #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 21,
    parameter int DATA_WIDTH = 16,
    parameter int TO_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [TO_WIDTH-1:0]          cfg_timeout,
    input  logic                         cfg_fixed_prio,
    input  logic [NUM_CH-1:0]            s_psel,
    input  logic [NUM_CH-1:0]            s_penable,
    input  logic [NUM_CH-1:0]            s_pwrite,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] s_paddr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_pwdata,
    output logic [DATA_WIDTH-1:0]        s_prdata,
    output logic [NUM_CH-1:0]            s_pready,
    output logic [NUM_CH-1:0]            s_pslverr,
    output logic                         req_sel,
    output logic                         req_write,
    output logic [ADDR_WIDTH-1:0]        req_addr,
    output logic [DATA_WIDTH-1:0]        req_wdata,
    input  logic                         req_ready,
    input  logic [DATA_WIDTH-1:0]        req_rdata,
    input  logic                         req_err,
    output logic                         busy,
    output logic [$clog2(NUM_CH)-1:0]    grant_id,
    output logic                         timeout_evt
);
    localparam int IW = $clog2(NUM_CH);

    typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

    state_t                state, state_n;
    logic [IW-1:0]         rr_ptr, rr_ptr_n, grant_n, win, idx;
    logic [TO_WIDTH-1:0]   to_cnt, to_cnt_n;
    logic                  fixed_q, fixed_n, found;
    logic [NUM_CH-1:0]     req_vec, pready_n, pslverr_n;
    logic                  sel_n, write_n, tevt_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [DATA_WIDTH-1:0] wdata_n, prdata_n;
    int                    base;

    assign req_vec = s_psel & s_penable;

    // Winner: first requester at or above the search base, wrapping; base is 0 in fixed mode.
    always_comb begin
        base  = cfg_fixed_prio ? 0 : int'(rr_ptr);
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = IW'((base + k) % NUM_CH);
            if (!found && req_vec[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_n   = state;
        rr_ptr_n  = rr_ptr;
        to_cnt_n  = to_cnt;
        fixed_n   = fixed_q;
        grant_n   = grant_id;
        sel_n     = 1'b0;
        write_n   = req_write;
        addr_n    = req_addr;
        wdata_n   = req_wdata;
        prdata_n  = s_prdata;
        pready_n  = '0;
        pslverr_n = '0;
        tevt_n    = 1'b0;
        case (state)
            IDLE: if (found) begin
                state_n  = REQ;
                grant_n  = win;
                sel_n    = 1'b1;
                write_n  = s_pwrite[win];
                addr_n   = s_paddr[win*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_n  = s_pwdata[win*DATA_WIDTH +: DATA_WIDTH];
                to_cnt_n = TO_WIDTH'(1);
                // Mode is frozen per transfer so the pointer update matches the grant decision.
                fixed_n  = cfg_fixed_prio;
            end
            REQ: begin
                to_cnt_n = (to_cnt == '1) ? to_cnt : to_cnt + 1'b1;
                if (req_ready) begin
                    state_n             = RESP;
                    prdata_n            = req_rdata;
                    pready_n[grant_id]  = 1'b1;
                    pslverr_n[grant_id] = req_err;
                    to_cnt_n            = '0;
                end else if (cfg_timeout != '0 && to_cnt == cfg_timeout) begin
                    state_n             = ERR;
                    tevt_n              = 1'b1;
                    prdata_n            = '0;
                    pready_n[grant_id]  = 1'b1;
                    pslverr_n[grant_id] = 1'b1;
                    to_cnt_n            = '0;
                end else begin
                    sel_n = 1'b1;
                end
            end
            default: begin
                state_n  = IDLE;
                rr_ptr_n = fixed_q ? rr_ptr : IW'((int'(grant_id) + 1) % NUM_CH);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            to_cnt      <= '0;
            fixed_q     <= 1'b0;
            grant_id    <= '0;
            req_sel     <= 1'b0;
            req_write   <= 1'b0;
            req_addr    <= '0;
            req_wdata   <= '0;
            s_prdata    <= '0;
            s_pready    <= '0;
            s_pslverr   <= '0;
            timeout_evt <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            rr_ptr      <= rr_ptr_n;
            to_cnt      <= to_cnt_n;
            fixed_q     <= fixed_n;
            grant_id    <= grant_n;
            req_sel     <= sel_n;
            req_write   <= write_n;
            req_addr    <= addr_n;
            req_wdata   <= wdata_n;
            s_prdata    <= prdata_n;
            s_pready    <= pready_n;
            s_pslverr   <= pslverr_n;
            timeout_evt <= tevt_n;
            busy        <= (state_n != IDLE);
        end
    end
endmodule

// File: tb/tb_apb_arbiter_rr.sv
// tb_apb_arbiter_rr: directed and randomized transactions against a transaction-level model.
module tb_apb_arbiter_rr;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] cfg_timeout = '0;
    logic        cfg_fixed_prio = 1'b0;
    logic [3:0]  s_psel = '0, s_penable = '0, s_pwrite = '0;
    logic [83:0] s_paddr = '0;
    logic [63:0] s_pwdata = '0;
    logic [15:0] s_prdata;
    logic [3:0]  s_pready, s_pslverr;
    logic        req_sel, req_write;
    logic [20:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready = 1'b0;
    logic [15:0] req_rdata = '0;
    logic        req_err = 1'b0;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout_evt;

    int tests = 0, fails = 0;
    int ptr = 0;
    logic [20:0] addr [4];
    logic [15:0] wd [4];
    logic        wr [4];
    int g;

    apb_arbiter_rr #(.NUM_CH(4), .ADDR_WIDTH(21), .DATA_WIDTH(16), .TO_WIDTH(16)) dut (
        .clk(clk), .rstn(rstn), .cfg_timeout(cfg_timeout), .cfg_fixed_prio(cfg_fixed_prio),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite), .s_paddr(s_paddr),
        .s_pwdata(s_pwdata), .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
        .req_sel(req_sel), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .req_rdata(req_rdata), .req_err(req_err), .busy(busy),
        .grant_id(grant_id), .timeout_evt(timeout_evt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
        tests++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    // Winner = requesting channel nearest upward from the pointer (or lowest index in fixed mode).
    function automatic int pick(input logic [3:0] r, input bit fx);
        int best, bd, d;
        best = -1;
        bd = 99;
        for (int c = 0; c < 4; c++) begin
            d = fx ? c : (c - ptr + 4) % 4;
            if (r[c] && d < bd) begin
                bd = d;
                best = c;
            end
        end
        return best;
    endfunction

    task automatic rand_chan();
        for (int i = 0; i < 4; i++) begin
            addr[i] = 21'($urandom);
            wd[i] = 16'($urandom);
            wr[i] = 1'($urandom);
        end
    endtask

    task automatic txn(input logic [3:0] reqs, input bit drop, input int delay, input int tmo,
                       input logic [15:0] rd, input logic err, output int gid);
        int e, n;
        bit resp;
        e = pick(reqs, cfg_fixed_prio);
        resp = (delay >= 1) && (tmo == 0 || delay <= tmo);
        n = resp ? delay : tmo;
        cfg_timeout = 16'(tmo);
        for (int i = 0; i < 4; i++) begin
            s_paddr[i*21 +: 21] = addr[i];
            s_pwdata[i*16 +: 16] = wd[i];
            s_pwrite[i] = wr[i];
        end
        s_psel = reqs;
        s_penable = reqs;
        step();
        gid = int'(grant_id);
        chk("grant_latency", {31'b0, req_sel}, 1);
        chk("grant_id", {30'b0, grant_id}, e);
        chk("req_addr", {11'b0, req_addr}, {11'b0, addr[e]});
        chk("req_wdata", {16'b0, req_wdata}, {16'b0, wd[e]});
        chk("req_write", {31'b0, req_write}, {31'b0, wr[e]});
        if (drop) begin
            s_psel = '0;
            s_penable = '0;
        end
        for (int c = 1; c <= n; c++) begin
            chk("req_sel_hold", {29'b0, req_sel, timeout_evt, |s_pready}, 32'h4);
            req_ready = resp && c == n;
            req_rdata = rd;
            req_err = err;
            step();
            req_ready = 1'b0;
            req_rdata = 16'($urandom);
            req_err = 1'($urandom);
        end
        chk("pready", {28'b0, s_pready}, 32'(1 << e));
        chk("pslverr", {28'b0, s_pslverr}, resp ? 32'(err) << e : 32'(1 << e));
        chk("prdata", {16'b0, s_prdata}, resp ? {16'b0, rd} : 0);
        chk("timeout_evt", {31'b0, timeout_evt}, resp ? 0 : 1);
        chk("sel_drop", {30'b0, req_sel, busy}, 1);
        step();
        chk("resp_one_cycle", {22'b0, s_pready, s_pslverr, timeout_evt, busy}, 0);
        if (!cfg_fixed_prio) ptr = (e + 1) % 4;
    endtask

    initial begin
        #1;
        chk("rst_out", {busy, req_sel, req_write, timeout_evt, s_pready, s_pslverr, grant_id, 14'b0}, 0);
        chk("rst_data", {s_prdata, req_wdata}, 0);
        chk("rst_addr", {11'b0, req_addr}, 0);
        step();
        step();
        rstn = 1'b1;
        s_psel = 4'hF;
        req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("psel_no_penable", {26'b0, req_sel, busy, s_pready}, 0);
        end
        s_psel = '0;
        req_ready = 1'b0;
        rand_chan();
        for (int i = 0; i < 5; i++) begin
            txn(4'hF, 0, $urandom_range(1, 4), 0, 16'($urandom), 1'($urandom), g);
            chk("rr_order", g, i % 4);
        end
        rand_chan();
        addr[1] = 21'h00123;
        wr[1] = 1'b0;
        txn(4'b0010, 0, 3, 0, 16'hBEEF, 1'b0, g);
        chk("ch1_read", g, 1);
        cfg_fixed_prio = 1'b1;
        txn(4'b0101, 0, 2, 0, 16'h1111, 1'b0, g);
        chk("fixed_first", g, 0);
        txn(4'b0100, 0, 2, 0, 16'h2222, 1'b1, g);
        chk("fixed_next", g, 2);
        cfg_fixed_prio = 1'b0;
        txn(4'b0001, 0, 0, 5, 16'h3333, 1'b0, g);
        txn(4'b0100, 0, 5, 5, 16'h4444, 1'b0, g);
        txn(4'b1000, 0, 1000, 0, 16'h5555, 1'b0, g);
        txn(4'b1000, 1, 4, 0, 16'h6666, 1'b1, g);
        for (int i = 0; i < 40; i++) begin
            int tmo, dly;
            logic [3:0] r;
            rand_chan();
            cfg_fixed_prio = 1'($urandom);
            r = 4'($urandom_range(1, 15));
            tmo = $urandom_range(0, 1) ? 0 : $urandom_range(2, 6);
            dly = $urandom_range(0, 8);
            if (tmo == 0 && dly == 0) dly = 1;
            txn(r, 1'($urandom), dly, tmo, 16'($urandom), 1'($urandom), g);
        end
        cfg_fixed_prio = 1'b0;
        txn(4'b0001, 0, 2, 0, 16'h7777, 1'b0, g);
        txn(4'b0010, 0, 2, 0, 16'h8888, 1'b0, g);
        s_psel = 4'b0100;
        s_penable = 4'b0100;
        cfg_timeout = 16'd0;
        step();
        step();
        step();
        chk("pre_reset_req", {30'b0, req_sel, busy}, 3);
        rstn = 1'b0;
        #1;
        chk("async_rst_ctl", {busy, req_sel, req_write, timeout_evt, s_pready, s_pslverr, grant_id, 14'b0}, 0);
        chk("async_rst_data", {s_prdata, req_wdata}, 0);
        chk("async_rst_addr", {11'b0, req_addr}, 0);
        s_psel = '0;
        s_penable = '0;
        req_ready = 1'b1;
        step();
        rstn = 1'b1;
        ptr = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("no_pready_after_rst", {26'b0, req_sel, busy, s_pready}, 0);
        end
        req_ready = 1'b0;
        rand_chan();
        txn(4'b1010, 0, 2, 0, 16'h9999, 1'b0, g);
        chk("post_reset_grant", g, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
